// File: rtl/fwft_burst_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fwft_arb_pkg
// Shared definitions for the FWFT burst arbiter:
//   state_e  - scheduler states (IDLE, ARB, BURST, WAIT)
//   clog2    - ceiling log2, never less than 1 so a 2-entry index is 1 bit
//   CHW      - channel index width for the default channel count
// -----------------------------------------------------------------------------
package fwft_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        BURST = 2'd2,
        WAIT  = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int NCH_DEFAULT = 4;
    localparam int CHW         = clog2(NCH_DEFAULT);

endpackage

// File: rtl/fwft_burst_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches the request vector starting at the
// entry just after ptr_i and wrapping modulo NCH, so the last winner has the
// lowest priority.
//   req_i  - request vector
//   ptr_i  - index of the previous winner
//   gnt_o  - one-hot grant (zero when no request)
//   idx_o  - binary index of the granted entry
//   any_o  - at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [CW-1:0]  idx_o,
    output logic           any_o
);

    always_comb begin
        int sel;
        sel   = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            sel = (int'(ptr_i) + i) % NCH;
            if (!any_o && req_i[sel]) begin
                any_o      = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = CW'(sel);
            end
        end
    end

endmodule

// File: rtl/fwft_burst_arbiter.sv
// -----------------------------------------------------------------------------
// fwft_burst_arbiter
// Shares one registered valid/ready stream among NCH FWFT channel FIFOs.
// Channels are granted round-robin; each grant pops a burst of cfg_burst words
// (0 counts as 1). A channel that runs dry mid-burst is waited on for TIMEOUT
// cycles before the burst is abandoned with a one-cycle burst_abort pulse.
// Ports:
//   pos_rclk, aresetn_rclk (async, low), sresetn_rclk (sync, low)
//   ch_empty/ch_dout/ch_rd_en  - FWFT read side of the channel FIFOs
//   cfg_ch_enable, cfg_burst   - sampled only when arbitrating
//   m_data/m_valid/m_ready/m_chan/m_last - output stream
//   burst_abort - timeout pulse, busy - BURST or WAIT
// -----------------------------------------------------------------------------
module fwft_burst_arbiter
    import fwft_arb_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 16,
    parameter int BW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  pos_rclk,
    input  logic                  aresetn_rclk,
    input  logic                  sresetn_rclk,
    input  logic [NCH-1:0]        ch_empty,
    input  logic [NCH*DW-1:0]     ch_dout,
    output logic [NCH-1:0]        ch_rd_en,
    input  logic [NCH-1:0]        cfg_ch_enable,
    input  logic [BW-1:0]         cfg_burst,
    output logic [DW-1:0]         m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [clog2(NCH)-1:0] m_chan,
    output logic                  m_last,
    output logic                  burst_abort,
    output logic                  busy
);

    localparam int CW = clog2(NCH);
    localparam int TW = clog2(TIMEOUT + 1);

    state_e          state_q;
    logic [CW-1:0]   ptr_q;
    logic [CW-1:0]   g_q;
    logic [NCH-1:0]  g_oh_q;
    logic [BW-1:0]   len_q;
    logic [BW-1:0]   cnt_q;
    logic [TW-1:0]   tmo_q;
    logic            m_valid_q;
    logic [DW-1:0]   m_data_q;
    logic [CW-1:0]   m_chan_q;
    logic            m_last_q;
    logic            burst_abort_q;

    logic [NCH-1:0]  req;
    logic [NCH-1:0]  pick_oh;
    logic [CW-1:0]   pick_idx;
    logic            pick_any;
    logic            empty_g;
    logic [DW-1:0]   head_g;
    logic            load_d;
    logic            last_d;

    assign req = cfg_ch_enable & ~ch_empty;

    rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Granted channel's FWFT head, selected with the latched one-hot grant.
    assign empty_g = |(ch_empty & g_oh_q);

    always_comb begin
        head_g = '0;
        for (int i = 0; i < NCH; i++) begin
            if (g_oh_q[i]) head_g = head_g | ch_dout[i*DW +: DW];
        end
    end

    // A pop happens only when the output register is free or draining this cycle.
    assign load_d   = (state_q == BURST) && !empty_g && (!m_valid_q || m_ready);
    assign last_d   = (cnt_q == len_q - BW'(1));
    assign ch_rd_en = load_d ? g_oh_q : '0;

    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            state_q       <= IDLE;
            ptr_q         <= CW'(NCH - 1);
            g_q           <= '0;
            g_oh_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_chan_q      <= '0;
            m_last_q      <= 1'b0;
            burst_abort_q <= 1'b0;
        end else if (!sresetn_rclk) begin
            state_q       <= IDLE;
            ptr_q         <= CW'(NCH - 1);
            g_q           <= '0;
            g_oh_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_chan_q      <= '0;
            m_last_q      <= 1'b0;
            burst_abort_q <= 1'b0;
        end else begin
            burst_abort_q <= 1'b0;

            if (load_d) begin
                m_valid_q <= 1'b1;
                m_data_q  <= head_g;
                m_chan_q  <= g_q;
                m_last_q  <= last_d;
                cnt_q     <= cnt_q + BW'(1);
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: state_q <= ARB;
                ARB: begin
                    if (pick_any) begin
                        g_q     <= pick_idx;
                        g_oh_q  <= pick_oh;
                        ptr_q   <= pick_idx;
                        len_q   <= (cfg_burst == '0) ? BW'(1) : cfg_burst;
                        cnt_q   <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (load_d && last_d) begin
                        state_q <= ARB;
                    end else if (empty_g) begin
                        state_q <= WAIT;
                        tmo_q   <= '0;
                    end
                end
                WAIT: begin
                    // Fresh data wins over a timeout expiring in the same cycle.
                    if (!empty_g) begin
                        state_q <= BURST;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        burst_abort_q <= 1'b1;
                        state_q       <= ARB;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_chan      = m_chan_q;
    assign m_last      = m_last_q;
    assign burst_abort = burst_abort_q;
    assign busy        = (state_q == BURST) || (state_q == WAIT);

endmodule

// File: tb/tb_fwft_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fwft_burst_arbiter
// Directed bench: FWFT FIFO models feed the arbiter; a negedge monitor logs
// every accepted stream word and flags protocol slips; scenario tasks compare
// the log against hand-computed sequences.
// -----------------------------------------------------------------------------
module tb_fwft_burst_arbiter;
    import fwft_arb_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int BW  = 8;
    localparam int TO  = 10;
    localparam int CW  = CHW;

    logic              pos_rclk = 1'b0;
    logic              aresetn_rclk;
    logic              sresetn_rclk;
    logic [NCH-1:0]    ch_empty;
    logic [NCH*DW-1:0] ch_dout;
    logic [NCH-1:0]    ch_rd_en;
    logic [NCH-1:0]    cfg_ch_enable;
    logic [BW-1:0]     cfg_burst;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_ready;
    logic [CW-1:0]     m_chan;
    logic              m_last;
    logic              burst_abort;
    logic              busy;

    fwft_burst_arbiter #(.NCH(NCH), .DW(DW), .BW(BW), .TIMEOUT(TO)) dut (
        .pos_rclk      (pos_rclk),
        .aresetn_rclk  (aresetn_rclk),
        .sresetn_rclk  (sresetn_rclk),
        .ch_empty      (ch_empty),
        .ch_dout       (ch_dout),
        .ch_rd_en      (ch_rd_en),
        .cfg_ch_enable (cfg_ch_enable),
        .cfg_burst     (cfg_burst),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_chan        (m_chan),
        .m_last        (m_last),
        .burst_abort   (burst_abort),
        .busy          (busy)
    );

    always #5 pos_rclk = ~pos_rclk;

    // FWFT FIFO models: tasks advance wr_ptr, the pop process advances rd_ptr.
    logic [DW-1:0] mem [NCH][256];
    int wr_ptr [NCH];
    int rd_ptr [NCH] = '{0, 0, 0, 0};

    always @(posedge pos_rclk) begin
        for (int i = 0; i < NCH; i++)
            if (ch_rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_fifo
        assign ch_empty[g]          = (rd_ptr[g] == wr_ptr[g]);
        assign ch_dout[g*DW +: DW]  = mem[g][rd_ptr[g] % 256];
    end

    // Stream monitor
    int            cyc = 0;
    logic [DW-1:0] log_data [512];
    logic [CW-1:0] log_chan [512];
    logic          log_last [512];
    int            log_cyc  [512];
    int            log_n = 0;
    int            abort_cnt = 0, abort_cyc = 0;
    int            empty_pop_err = 0, stall_pop_err = 0, onehot_err = 0, hold_err = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge pos_rclk) cyc <= cyc + 1;

    always @(negedge pos_rclk) begin
        if (aresetn_rclk === 1'b1) begin
            if (m_valid && m_ready && log_n < 512) begin
                log_data[log_n] = m_data;
                log_chan[log_n] = m_chan;
                log_last[log_n] = m_last;
                log_cyc[log_n]  = cyc;
                log_n++;
            end
            if (burst_abort) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
            if ((ch_rd_en & ch_empty) != '0) empty_pop_err++;
            if (ch_rd_en != '0 && m_valid && !m_ready) stall_pop_err++;
            if ($countones(ch_rd_en) > 1) onehot_err++;
            if (prev_stall && (!m_valid || m_data !== prev_data)) hold_err++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge pos_rclk);
        #1;
    endtask

    task automatic push(input int ch, input logic [DW-1:0] val);
        mem[ch][wr_ptr[ch] % 256] = val;
        wr_ptr[ch]++;
    endtask

    task automatic test_reset();
        aresetn_rclk  = 1'b0;
        sresetn_rclk  = 1'b1;
        m_ready       = 1'b1;
        cfg_ch_enable = '0;
        cfg_burst     = '0;
        for (int i = 0; i < NCH; i++) wr_ptr[i] = 0;
        repeat (3) tick();
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %h expected 0000", m_data); end
        n_vec++; if (m_chan !== '0) begin n_err++; $display("FAIL reset_m_chan: got %0d expected 0", m_chan); end
        n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        n_vec++; if (burst_abort !== 1'b0) begin n_err++; $display("FAIL reset_abort: got %b expected 0", burst_abort); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (ch_rd_en !== '0) begin n_err++; $display("FAIL reset_rd_en: got %b expected 0000", ch_rd_en); end
        aresetn_rclk = 1'b1;
        repeat (3) tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        int s;
        s = log_n;
        cfg_burst     = 8'd3;
        cfg_ch_enable = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            push(0, 16'h0A00 + 16'(k));
            push(2, 16'h2A00 + 16'(k));
        end
        for (int t = 0; t < 200 && log_n < s + 12; t++) tick();
        n_vec++; if (log_n < s + 12) begin n_err++; $display("FAIL rr_words: got %0d expected 12 within budget", log_n - s); end
        for (int k = 0; k < 12; k++) begin
            int b, ch;
            logic [DW-1:0] exp;
            b   = k / 3;
            ch  = (b % 2 == 0) ? 0 : 2;
            exp = ((ch == 0) ? 16'h0A00 : 16'h2A00) + 16'((b / 2) * 3 + k % 3);
            n_vec++; if (log_data[s+k] !== exp) begin n_err++; $display("FAIL rr_data[%0d]: got %h expected %h", k, log_data[s+k], exp); end
            n_vec++; if (log_chan[s+k] !== CW'(ch)) begin n_err++; $display("FAIL rr_chan[%0d]: got %0d expected %0d", k, log_chan[s+k], ch); end
            n_vec++; if (log_last[s+k] !== (k % 3 == 2)) begin n_err++; $display("FAIL rr_last[%0d]: got %b expected %b", k, log_last[s+k], (k % 3 == 2)); end
            if (k > 0) begin
                n_vec++;
                if (log_cyc[s+k] - log_cyc[s+k-1] != ((k % 3 == 0) ? 2 : 1)) begin
                    n_err++; $display("FAIL rr_gap[%0d]: got %0d expected %0d", k, log_cyc[s+k] - log_cyc[s+k-1], (k % 3 == 0) ? 2 : 1);
                end
            end
        end
        repeat (5) tick();
        n_vec++; if (log_n != s + 12) begin n_err++; $display("FAIL rr_extra: got %0d words expected 12", log_n - s); end
    endtask

    task automatic test_timeout();
        int s, a0;
        s  = log_n;
        a0 = abort_cnt;
        cfg_burst     = 8'd4;
        cfg_ch_enable = 4'b0010;
        push(1, 16'h1B00);
        push(1, 16'h1B01);
        for (int t = 0; t < 100 && abort_cnt == a0; t++) tick();
        repeat (3) tick();
        n_vec++; if (log_n - s != 2) begin n_err++; $display("FAIL to_words: got %0d expected 2", log_n - s); end
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (log_data[s+k] !== 16'h1B00 + 16'(k)) begin n_err++; $display("FAIL to_data[%0d]: got %h expected %h", k, log_data[s+k], 16'h1B00 + 16'(k)); end
            n_vec++; if (log_chan[s+k] !== CW'(1)) begin n_err++; $display("FAIL to_chan[%0d]: got %0d expected 1", k, log_chan[s+k]); end
            n_vec++; if (log_last[s+k] !== 1'b0) begin n_err++; $display("FAIL to_last[%0d]: got %b expected 0", k, log_last[s+k]); end
        end
        n_vec++; if (abort_cnt - a0 != 1) begin n_err++; $display("FAIL to_abort_count: got %0d expected 1", abort_cnt - a0); end
        n_vec++; if (abort_cyc - log_cyc[s+1] != 11) begin n_err++; $display("FAIL to_abort_delay: got %0d expected 11", abort_cyc - log_cyc[s+1]); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_back_to_arb: busy %b expected 0", busy); end
    endtask

    task automatic test_refill();
        int s, a0;
        s  = log_n;
        a0 = abort_cnt;
        cfg_burst     = 8'd4;
        cfg_ch_enable = 4'b0010;
        push(1, 16'h1C00);
        push(1, 16'h1C01);
        for (int t = 0; t < 50 && log_n < s + 2; t++) tick();
        repeat (4) tick();
        push(1, 16'h1C02);
        push(1, 16'h1C03);
        for (int t = 0; t < 50 && log_n < s + 4; t++) tick();
        repeat (15) tick();
        n_vec++; if (log_n - s != 4) begin n_err++; $display("FAIL rf_words: got %0d expected 4", log_n - s); end
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (log_data[s+k] !== 16'h1C00 + 16'(k)) begin n_err++; $display("FAIL rf_data[%0d]: got %h expected %h", k, log_data[s+k], 16'h1C00 + 16'(k)); end
            n_vec++; if (log_last[s+k] !== (k == 3)) begin n_err++; $display("FAIL rf_last[%0d]: got %b expected %b", k, log_last[s+k], (k == 3)); end
        end
        n_vec++; if (log_cyc[s+3] - log_cyc[s+1] != 8) begin n_err++; $display("FAIL rf_resume: got %0d expected 8", log_cyc[s+3] - log_cyc[s+1]); end
        n_vec++; if (abort_cnt != a0) begin n_err++; $display("FAIL rf_no_abort: got %0d aborts expected 0", abort_cnt - a0); end
    endtask

    task automatic test_random_ready();
        int s, p0, h0;
        s  = log_n;
        p0 = stall_pop_err;
        h0 = hold_err;
        cfg_burst     = 8'd8;
        cfg_ch_enable = 4'b1000;
        for (int k = 0; k < 8; k++) push(3, 16'h3D00 + 16'(k));
        for (int t = 0; t < 400 && log_n < s + 8; t++) begin
            m_ready = ($urandom_range(0, 9) < 3);
            tick();
        end
        m_ready = 1'b1;
        repeat (3) tick();
        n_vec++; if (log_n - s != 8) begin n_err++; $display("FAIL rnd_words: got %0d expected 8", log_n - s); end
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (log_data[s+k] !== 16'h3D00 + 16'(k)) begin n_err++; $display("FAIL rnd_data[%0d]: got %h expected %h", k, log_data[s+k], 16'h3D00 + 16'(k)); end
            n_vec++; if (log_chan[s+k] !== CW'(3)) begin n_err++; $display("FAIL rnd_chan[%0d]: got %0d expected 3", k, log_chan[s+k]); end
            n_vec++; if (log_last[s+k] !== (k == 7)) begin n_err++; $display("FAIL rnd_last[%0d]: got %b expected %b", k, log_last[s+k], (k == 7)); end
        end
        n_vec++; if (stall_pop_err != p0) begin n_err++; $display("FAIL rnd_pop_on_stall: got %0d expected 0", stall_pop_err - p0); end
        n_vec++; if (hold_err != h0) begin n_err++; $display("FAIL rnd_hold: got %0d unstable cycles expected 0", hold_err - h0); end
    endtask

    task automatic test_narrow_enable();
        int s;
        s = log_n;
        cfg_burst     = 8'd0;
        cfg_ch_enable = 4'b0101;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 4; k++) push(c, 16'h4000 + 16'(c * 256 + k));
        for (int t = 0; t < 100 && log_n < s + 8; t++) tick();
        repeat (4) tick();
        n_vec++; if (log_n - s != 8) begin n_err++; $display("FAIL en_words: got %0d expected 8", log_n - s); end
        for (int k = 0; k < 8; k++) begin
            int ch;
            ch = (k % 2) * 2;
            n_vec++; if (log_chan[s+k] !== CW'(ch)) begin n_err++; $display("FAIL en_chan[%0d]: got %0d expected %0d", k, log_chan[s+k], ch); end
            n_vec++; if (log_data[s+k] !== 16'h4000 + 16'(ch * 256 + k / 2)) begin n_err++; $display("FAIL en_data[%0d]: got %h expected %h", k, log_data[s+k], 16'h4000 + 16'(ch * 256 + k / 2)); end
            n_vec++; if (log_last[s+k] !== 1'b1) begin n_err++; $display("FAIL en_last[%0d]: got %b expected 1", k, log_last[s+k]); end
            if (k > 0) begin
                n_vec++; if (log_cyc[s+k] - log_cyc[s+k-1] != 2) begin n_err++; $display("FAIL en_gap[%0d]: got %0d expected 2", k, log_cyc[s+k] - log_cyc[s+k-1]); end
            end
        end
        n_vec++; if (wr_ptr[1] - rd_ptr[1] != 4) begin n_err++; $display("FAIL en_ch1_untouched: got %0d words expected 4", wr_ptr[1] - rd_ptr[1]); end
        n_vec++; if (wr_ptr[3] - rd_ptr[3] != 4) begin n_err++; $display("FAIL en_ch3_untouched: got %0d words expected 4", wr_ptr[3] - rd_ptr[3]); end
        cfg_ch_enable = '0;
        tick();
        for (int c = 0; c < NCH; c++) wr_ptr[c] = rd_ptr[c];
        tick();
    endtask

    task automatic test_reset_midburst();
        int r0, s2;
        r0 = rd_ptr[0];
        cfg_burst     = 8'd5;
        cfg_ch_enable = 4'b0001;
        for (int k = 0; k < 5; k++) push(0, 16'h5000 + 16'(k));
        for (int t = 0; t < 50 && rd_ptr[0] - r0 < 2; t++) tick();
        aresetn_rclk  = 1'b0;
        cfg_ch_enable = 4'b0011;
        for (int k = 0; k < 5; k++) push(1, 16'h5100 + 16'(k));
        #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mr_m_valid: got %b expected 0", m_valid); end
        n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL mr_m_data: got %h expected 0000", m_data); end
        n_vec++; if (m_chan !== '0) begin n_err++; $display("FAIL mr_m_chan: got %0d expected 0", m_chan); end
        n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL mr_m_last: got %b expected 0", m_last); end
        n_vec++; if (ch_rd_en !== '0) begin n_err++; $display("FAIL mr_rd_en: got %b expected 0000", ch_rd_en); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mr_busy: got %b expected 0", busy); end
        repeat (2) tick();
        n_vec++; if (rd_ptr[0] - r0 != 2) begin n_err++; $display("FAIL mr_pops: got %0d expected 2", rd_ptr[0] - r0); end
        s2 = log_n;
        aresetn_rclk = 1'b1;
        for (int t = 0; t < 50 && log_n < s2 + 1; t++) tick();
        n_vec++; if (log_chan[s2] !== CW'(0)) begin n_err++; $display("FAIL mr_first_grant: got %0d expected 0", log_chan[s2]); end
        n_vec++; if (log_data[s2] !== 16'h5002) begin n_err++; $display("FAIL mr_first_data: got %h expected 5002", log_data[s2]); end
        repeat (60) tick();
        n_vec++; if (empty_pop_err != 0) begin n_err++; $display("FAIL pop_on_empty: got %0d expected 0", empty_pop_err); end
        n_vec++; if (onehot_err != 0) begin n_err++; $display("FAIL rd_en_onehot: got %0d expected 0", onehot_err); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_timeout();
        test_refill();
        test_random_ready();
        test_narrow_enable();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwft_burst_arbiter.md
Name: fwft_burst_arbiter

Overview:
- Read-side scheduler that shares one downstream stream among NCH first-word-fall-through (FWFT) channel FIFOs, one per digitizer channel.
- Grants channels round-robin; for each grant it pops a fixed-length burst from that channel's FWFT output.
- Presents bursts on a registered valid/ready stream with channel ID and last-word marker.
- Sits between the per-channel FWFT FIFO outputs and the packetizer/DMA, all in the read clock domain.

Parameters:
- NCH, 4, number of channel FIFOs (2..16).
- DW, 16, data width of each channel FIFO output and of m_data.
- BW, 8, width of cfg_burst.
- TIMEOUT, 255, cycles to wait for a starved channel mid-burst before aborting (≥1).

Ports:
- pos_rclk  in  1  read clock, rising edge.
- aresetn_rclk  in  1  asynchronous reset, active-low.
- sresetn_rclk  in  1  synchronous reset, active-low; same reset values as aresetn_rclk.
- ch_empty  in  NCH  per-channel FWFT empty; ch_dout slice valid when low.
- ch_dout  in  NCH*DW  per-channel FWFT data; channel i occupies bits [i*DW +: DW].
- ch_rd_en  out  NCH  per-channel pop, active-high, one-hot or zero.
- cfg_ch_enable  in  NCH  channel participates in arbitration when high.
- cfg_burst  in  BW  words per burst; 0 is treated as 1.
- m_data  out  DW  stream data, registered.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_chan  out  clog2(NCH)  source channel of m_data.
- m_last  out  1  final word of burst.
- burst_abort  out  1  one-cycle pulse: burst terminated by timeout.
- busy  out  1  high in any state other than IDLE/ARB.

Behaviour:
- Reset: state=IDLE; ch_rd_en=0, m_valid=0, m_data=0, m_chan=0, m_last=0, burst_abort=0, busy=0; grant pointer=NCH-1, so channel 0 has first priority.
- Both resets act identically. A reset mid-burst drops the output register contents and the burst with no m_last.
- FWFT rule:
  - Word is available when ch_empty[g]=0.
  - ch_rd_en[g]=1 consumes it in that cycle; the next word, or empty, is visible the next cycle.
  - ch_rd_en is never asserted to an empty channel.
- Load condition: load = (state==BURST) & !ch_empty[g] & (!m_valid | m_ready).
  - ch_rd_en[g] = load, combinational.
  - On load, m_data, m_chan and m_last register at the same edge: latency 1 cycle from pop to m_valid.
- m_valid clears on m_ready when no new load occurs. It holds with data stable while m_ready=0 (no drop, no duplicate).
- States:
  - IDLE: exits to ARB the cycle after reset release.
  - ARB: requesters = cfg_ch_enable & ~ch_empty. If none, stay. Otherwise grant g = first requester after the pointer, wrapping modulo NCH. Update pointer=g, latch len=max(cfg_burst,1), clear cnt. → BURST. Arbitration costs exactly 1 cycle.
  - BURST: each load increments cnt. m_last=1 on the load where cnt==len-1, then → ARB. If ch_empty[g]=1 and no load is possible → WAIT, and the timeout counter clears.
  - WAIT: if ch_empty[g]=0 → BURST; the load may occur the next cycle. The timeout counter increments per cycle. At count==TIMEOUT: pulse burst_abort, → ARB. The last emitted word of an aborted burst keeps m_last=0.
- Ordering rules:
  - cfg_burst and cfg_ch_enable changes take effect only at the next ARB.
  - Deasserting the enable of the granted channel does not abort its burst.
- A single requester is re-granted consecutively, with one ARB cycle between bursts.
- Back-to-back: a load and an m_ready acceptance in the same cycle sustain 1 word/cycle within a burst.
- cnt is BW bits wide. len=2^BW-1 must work without overflow.

Decomposition:
- Shared package fwft_arb_pkg holds:
  - state enum: IDLE, ARB, BURST, WAIT
  - clog2 function
  - a CHW constant derived from NCH
- One sub-module: rr_arbiter.
  - Combinational round-robin pick from a request vector and a pointer.
  - Outputs a one-hot grant and a binary index.
  - Instantiated once.

Test Plan:
- NCH=4, cfg_burst=3, ch0 and ch2 each hold 6 words, m_ready=1 → grant order ch0, ch2, ch0, ch2; 3 words each; m_last on every 3rd word; 1 idle cycle between bursts.
- cfg_burst=4, ch1 holds 2 words, none refilled, TIMEOUT=10 → 2 words out with m_last=0; after 10 WAIT cycles burst_abort pulses once; state returns to ARB.
- Same as previous, but ch1 gets 2 more words at WAIT cycle 5 → burst completes; 4th word has m_last=1; no abort.
- Random m_ready at 30% duty, burst=8 from ch3 → output data sequence equals FIFO contents; no ch_rd_en while m_valid=1 and m_ready=0.
- cfg_burst=0 → 1-word bursts; cfg_ch_enable=0101 with all channels full → only ch0 and ch2 are granted, alternating.
- aresetn_rclk asserted mid-burst (cnt=2) → all outputs return to reset values immediately; after release, first grant goes to ch0.
